// File: rtl/seg_scan_display.sv
// seg_scan_display: double-buffered, blanked, blinkable time-multiplexed 7-segment driver with register bus.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [1:0]            rd_addr,
  output logic [31:0]           rd_data,
  output logic [NUM_DIGITS-1:0] seg_an,
  output logic [7:0]            seg_seg,
  output logic                  frame_done
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_q, blink_d, pend_q, pend_d;
  logic [31:0]           pend_data_q, pend_data_d, live_q, live_d;
  logic [23:0]           ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0] seg_an_q, seg_an_d;
  logic [7:0]            seg_seg_q, seg_seg_d;
  logic [7:0]            en, dp, bl;
  logic [3:0]            nib;
  logic                  slot_end, wrap, last_frame, lit, wr_dat, wr_ctl;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_end    = slot_q == SW'(SCAN_DIV - 1);
    wrap        = slot_end && dig_q == DW'(NUM_DIGITS - 1);
    last_frame  = frame_q == FW'(BLINK_DIV - 1);
    wr_dat      = wr_en && wr_addr == 2'd0;
    wr_ctl      = wr_en && wr_addr == 2'd1;
    slot_d      = slot_end ? '0 : slot_q + 1'b1;
    dig_d       = wrap ? '0 : slot_end ? dig_q + 1'b1 : dig_q;
    frame_d     = wrap ? (last_frame ? '0 : frame_q + 1'b1) : frame_q;
    blink_d     = blink_q ^ (wrap && last_frame);
    // On a wrap the old pending value goes live; a same-cycle write still lands and re-arms pending
    live_d      = wrap && pend_q ? pend_data_q : live_q;
    pend_d      = wr_dat || (pend_q && !wrap);
    pend_data_d = wr_dat ? wr_data : pend_data_q;
    ctrl_d      = wr_ctl ? wr_data[23:0] : ctrl_q;
    en          = ctrl_q[7:0];
    dp          = ctrl_q[15:8];
    bl          = ctrl_q[23:16];
    nib         = live_q[{dig_q, 2'b00} +: 4];
    lit         = slot_q >= SW'(BLANK_CYCLES) && en[dig_q] && !(bl[dig_q] && blink_q);
    seg_an_d    = ~(NUM_DIGITS'(lit) << dig_q);
    seg_seg_d   = lit ? {~dp[dig_q], hex7(nib)} : 8'hFF;
    rd_data     = rd_addr == 2'd0 ? pend_data_q :
                  rd_addr == 2'd1 ? {8'h00, ctrl_q} :
                  rd_addr == 2'd2 ? live_q :
                  {27'd0, pend_q, blink_q, 3'(dig_q)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      dig_q       <= '0;
      frame_q     <= '0;
      blink_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      live_q      <= '0;
      ctrl_q      <= 24'h0000FF;
      seg_an_q    <= '1;
      seg_seg_q   <= 8'hFF;
    end else begin
      slot_q      <= slot_d;
      dig_q       <= dig_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      live_q      <= live_d;
      ctrl_q      <= ctrl_d;
      seg_an_q    <= seg_an_d;
      seg_seg_q   <= seg_seg_d;
    end
  end

  assign seg_an     = seg_an_q;
  assign seg_seg    = seg_seg_q;
  assign frame_done = wrap;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: random/directed register traffic against a cycle-count reference model with a scoreboard.
module tb_seg_scan_display;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic [7:0]  seg_an;
  logic [7:0]  seg_seg;
  logic        frame_done;

  seg_scan_display #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .seg_an(seg_an), .seg_seg(seg_seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] an; logic [7:0] seg; logic fd;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, sb_n = 0;
  logic [7:0] hex_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  // Model state: elapsed cycles since reset release plus the register file
  int          m_c, md, mph;
  logic [23:0] m_ctrl;
  logic [31:0] m_live, m_pd;
  logic        m_pend;
  exp_t        e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c = 0; m_ctrl = 24'hFF; m_live = 0; m_pd = 0; m_pend = 0;
      q.delete();
    end else begin
      md = (m_c / 4) % 8;
      mph = (m_c / 64) % 2;
      e.an = 8'hFF;
      e.seg = 8'hFF;
      e.fd = ((m_c + 1) % 32) == 31;
      if (m_c % 4 >= 1 && m_ctrl[md] && !(m_ctrl[16 + md] && mph == 1)) begin
        e.an = ~(8'd1 << md);
        e.seg = {~m_ctrl[8 + md], hex_lut[(m_live >> (4 * md)) & 15][6:0]};
      end
      q.push_back(e);
      if (m_c % 32 == 31 && m_pend) begin
        m_live = m_pd;
        m_pend = 0;
      end
      if (wr_en && wr_addr == 2'd0) begin
        m_pd = wr_data;
        m_pend = 1;
      end
      if (wr_en && wr_addr == 2'd1) m_ctrl = wr_data[23:0];
      m_c++;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      check("rst_an", {24'd0, seg_an}, 32'hFF);
      check("rst_seg", {24'd0, seg_seg}, 32'hFF);
      check("rst_fd", {31'd0, frame_done}, 32'd0);
    end else if (q.size() > 0) begin
      x = q.pop_front();
      sb_n++;
      check("seg_an", {24'd0, seg_an}, {24'd0, x.an});
      check("seg_seg", {24'd0, seg_seg}, {24'd0, x.seg});
      check("frame_done", {31'd0, frame_done}, {31'd0, x.fd});
    end
  end

  function automatic logic [31:0] rd_exp(input logic [1:0] a);
    int d = (m_c / 4) % 8;
    int ph = (m_c / 64) % 2;
    return a == 2'd0 ? m_pd : a == 2'd1 ? {8'h00, m_ctrl} : a == 2'd2 ? m_live :
           {27'd0, m_pend, ph[0], d[2:0]};
  endfunction

  task automatic step(input logic we, input logic [1:0] wa, input logic [31:0] wd, input logic [1:0] ra);
    @(posedge clk);
    #2;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    #1;
    check($sformatf("rd_addr%0d", ra), rd_data, rd_exp(ra));
  endtask

  initial begin
    repeat (3) step(0, 0, 0, 1);
    @(posedge clk); #2 rst = 0;
    step(1, 1, 32'h0000_0012, 3);
    for (int i = 0; i < 45; i++) step(0, 0, 0, 2'($urandom_range(0, 3)));
    @(posedge clk); #2 rst = 1;
    #1;
    check("mid_rst_an", {24'd0, seg_an}, 32'hFF);
    check("mid_rst_seg", {24'd0, seg_seg}, 32'hFF);
    step(0, 0, 0, 1);
    step(0, 0, 0, 2);
    @(posedge clk); #2 rst = 0;
    for (int i = 0; i < 40 && m_c % 32 != 5; i++) step(0, 0, 0, 3);
    step(1, 0, 32'h0000_0246, 3);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 3);
    step(1, 1, 32'h0004_0203, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 3);
    step(1, 1, 32'h0004_0207, 1);
    for (int i = 0; i < 160; i++) step(0, 0, 0, 3);
    for (int i = 0; i < 40 && m_c % 32 != 31; i++) step(0, 0, 0, 3);
    step(1, 0, 32'hABCD_1234, 3);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 2'(i % 4));
    step(1, 2, $urandom, 2);
    step(1, 3, $urandom, 3);
    step(0, 0, 0, 2);
    step(1, 1, 32'hFF12_3456, 1);
    step(0, 0, 0, 1);
    step(1, 1, 32'h0000_0000, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 3);
    step(1, 1, 32'h0055_AAFF, 1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
    @(negedge clk);
    checks++;
    if (sb_n < 1000) begin
      errors++;
      $display("FAIL sb_count: got %0d scoreboard compares, required at least 1000", sb_n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
